// File: rtl/core_launch_seq_pkg.sv
// Shared types and constants for the core launch sequencer.
package core_launch_seq_pkg;

    localparam int unsigned CYCLE_CNT_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StBoot,
        StStart,
        StRun,
        StDone,
        StFault
    } launch_state_e;

endpackage

// File: rtl/core_launch_seq_sync_2ff.sv
// 1-bit two-flop synchronizer with synchronous reset to 0.
module core_launch_seq_sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/core_launch_seq.sv
// Launch sequencer for the asmodee core: flush, boot load, start pulse, then supervised run
// with halt detection and a cycle watchdog.
module core_launch_seq
    import core_launch_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   run_req_i,
    input  logic                   abort_i,
    input  logic                   halt_i,
    output logic                   core_rst_o,
    output logic                   core_boot_o,
    output logic                   core_start_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [CYCLE_CNT_W-1:0] cycle_count_o
);

    localparam int unsigned PhaseMax = (RST_CYCLES > BOOT_CYCLES) ? RST_CYCLES : BOOT_CYCLES;
    localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);

    localparam logic [PhaseW-1:0]      RstLoad  = PhaseW'(RST_CYCLES - 1);
    localparam logic [PhaseW-1:0]      BootLoad = PhaseW'(BOOT_CYCLES - 1);
    localparam logic [CYCLE_CNT_W-1:0] CntLast  = CYCLE_CNT_W'(TIMEOUT - 1);

    launch_state_e          state_q, state_d;
    logic [PhaseW-1:0]      phase_q, phase_d;
    logic [CYCLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   halt_sync;

    core_launch_seq_sync_2ff u_halt_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (halt_i),
        .q_o   (halt_sync)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            phase_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone, StFault: begin
                    if (run_req_i) begin
                        state_d = StReset;
                        phase_d = RstLoad;
                        cnt_d   = '0;
                    end
                end
                StReset: begin
                    if (phase_q == '0) begin
                        state_d = StBoot;
                        phase_d = BootLoad;
                    end else begin
                        phase_d = phase_q - 1'b1;
                    end
                end
                StBoot: begin
                    if (phase_q == '0) begin
                        state_d = StStart;
                    end else begin
                        phase_d = phase_q - 1'b1;
                    end
                end
                StStart: state_d = StRun;
                StRun: begin
                    // The exiting cycle is still a RUN cycle, so it is counted too.
                    cnt_d = cnt_q + 1'b1;
                    if (halt_sync) begin
                        state_d = StDone;
                    end else if (cnt_q == CntLast) begin
                        state_d = StFault;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        core_rst_o   = 1'b0;
        core_boot_o  = 1'b0;
        core_start_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        timeout_o    = 1'b0;
        case (state_q)
            StIdle:  core_rst_o = 1'b1;
            StReset: begin
                core_rst_o = 1'b1;
                busy_o     = 1'b1;
            end
            StBoot: begin
                core_boot_o = 1'b1;
                busy_o      = 1'b1;
            end
            StStart: begin
                core_boot_o  = 1'b1;
                core_start_o = 1'b1;
                busy_o       = 1'b1;
            end
            StRun:   busy_o    = 1'b1;
            StDone:  done_o    = 1'b1;
            StFault: timeout_o = 1'b1;
            default: core_rst_o = 1'b1;
        endcase
    end

    assign cycle_count_o = cnt_q;

    boot_start_excl_a: assert property (@(posedge clk_i)
        !(core_rst_o && (core_boot_o || core_start_o)));

endmodule

// File: tb/tb_core_launch_seq.sv
// Scoreboard bench for core_launch_seq: default instance plus a TIMEOUT=8 instance.
module tb_core_launch_seq;

    typedef struct {
        logic        is_fault;
        int unsigned count;
        int unsigned at_cyc;
        string       tag;
    } exp_t;

    localparam logic [5:0] SEQ_EXP [0:7] = '{
        6'b100100, 6'b100100, 6'b100100, 6'b100100,
        6'b010100, 6'b010100, 6'b011100, 6'b000100
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a = 1'b1, run_a = 1'b0, abort_a = 1'b0, halt_a = 1'b0;
    logic rst_b = 1'b1, run_b = 1'b0, abort_b = 1'b0, halt_b = 1'b0;
    logic core_rst_a, boot_a, start_a, busy_a, done_a, to_a;
    logic core_rst_b, boot_b, start_b, busy_b, done_b, to_b;
    logic [31:0] cnt_a, cnt_b;
    logic [5:0] outs_a, outs_b;

    assign outs_a = {core_rst_a, boot_a, start_a, busy_a, done_a, to_a};
    assign outs_b = {core_rst_b, boot_b, start_b, busy_b, done_b, to_b};

    core_launch_seq dut_a (
        .clk_i         (clk),
        .rst_i         (rst_a),
        .run_req_i     (run_a),
        .abort_i       (abort_a),
        .halt_i        (halt_a),
        .core_rst_o    (core_rst_a),
        .core_boot_o   (boot_a),
        .core_start_o  (start_a),
        .busy_o        (busy_a),
        .done_o        (done_a),
        .timeout_o     (to_a),
        .cycle_count_o (cnt_a)
    );

    core_launch_seq #(
        .TIMEOUT (8)
    ) dut_b (
        .clk_i         (clk),
        .rst_i         (rst_b),
        .run_req_i     (run_b),
        .abort_i       (abort_b),
        .halt_i        (halt_b),
        .core_rst_o    (core_rst_b),
        .core_boot_o   (boot_b),
        .core_start_o  (start_b),
        .busy_o        (busy_b),
        .done_o        (done_b),
        .timeout_o     (to_b),
        .cycle_count_o (cnt_b)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Returns with edge 0 just taken; base is the cyc value after edge 0.
    task automatic launch(input bit sel_b, output int unsigned base);
        if (sel_b) run_b = 1'b1; else run_a = 1'b1;
        base = cyc + 1;
        step();
        run_a = 1'b0;
        run_b = 1'b0;
    endtask

    task automatic check_seq_a(input string tag);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            check($sformatf("%s_seq%0d", tag, k), 32'(outs_a), 32'(SEQ_EXP[k]));
        end
        check({tag, "_run_cnt0"}, cnt_a, 32'd0);
    endtask

    task automatic push_exp(input bit sel_b, input logic f, input int unsigned c,
                            input int unsigned at, input string tag);
        exp_t e;
        e.is_fault = f;
        e.count    = c;
        e.at_cyc   = at;
        e.tag      = tag;
        if (sel_b) q_b.push_back(e); else q_a.push_back(e);
    endtask

    // Monitor: compare every rising done/timeout against the scoreboard.
    logic prev_a = 1'b0, prev_b = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((done_a | to_a) && !prev_a) begin
                if (q_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_unexpected_event: got done=%0b timeout=%0b want none",
                             done_a, to_a);
                end else begin
                    e = q_a.pop_front();
                    check({e.tag, "_fault"}, 32'(to_a), 32'(e.is_fault));
                    check({e.tag, "_count"}, cnt_a, e.count);
                    check({e.tag, "_cycle"}, cyc, e.at_cyc);
                end
            end
            if ((done_b | to_b) && !prev_b) begin
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected_event: got done=%0b timeout=%0b want none",
                             done_b, to_b);
                end else begin
                    e = q_b.pop_front();
                    check({e.tag, "_fault"}, 32'(to_b), 32'(e.is_fault));
                    check({e.tag, "_count"}, cnt_b, e.count);
                    check({e.tag, "_cycle"}, cyc, e.at_cyc);
                end
            end
            prev_a = done_a | to_a;
            prev_b = done_b | to_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned base;

        repeat (3) step();
        check("a_reset_outs", 32'(outs_a), 32'b100000);
        check("a_reset_cnt", cnt_a, 32'd0);
        check("b_reset_outs", 32'(outs_b), 32'b100000);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (10) step();
        check("a_idle_outs", 32'(outs_a), 32'b100000);
        check("a_idle_cnt", cnt_a, 32'd0);
        check("b_idle_outs", 32'(outs_b), 32'b100000);

        // Default launch; halt sampled at edge 27 -> DONE after edge 29, count 22.
        launch(1'b0, base);
        check_seq_a("a_run1");
        repeat (19) step();
        push_exp(1'b0, 1'b0, 22, base + 29, "a_halt1");
        halt_a = 1'b1;
        repeat (3) step();
        halt_a = 1'b0;
        repeat (3) step();
        check("a_done_outs", 32'(outs_a), 32'b000010);
        check("a_done_frozen", cnt_a, 32'd22);

        // Relaunch from DONE; halt sampled at edge 12 -> count 7.
        launch(1'b0, base);
        check("a_relaunch_clr", cnt_a, 32'd0);
        check_seq_a("a_run2");
        repeat (4) step();
        push_exp(1'b0, 1'b0, 7, base + 14, "a_halt2");
        halt_a = 1'b1;
        repeat (3) step();
        halt_a = 1'b0;
        step();

        // Abort during BOOT.
        launch(1'b0, base);
        repeat (4) step();
        check("a_boot_outs", 32'(outs_a), 32'b010100);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("a_abort_boot_outs", 32'(outs_a), 32'b100000);
        check("a_abort_boot_cnt", cnt_a, 32'd0);

        // Abort during RUN with count 3; the count is kept.
        launch(1'b0, base);
        check_seq_a("a_run3");
        repeat (3) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("a_abort_run_outs", 32'(outs_a), 32'b100000);
        check("a_abort_run_cnt", cnt_a, 32'd3);

        // Reset asserted mid-RUN.
        launch(1'b0, base);
        repeat (9) step();
        check("a_pre_rst_cnt", cnt_a, 32'd2);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("a_mid_rst_outs", 32'(outs_a), 32'b100000);
        check("a_mid_rst_cnt", cnt_a, 32'd0);

        // TIMEOUT=8, no halt -> FAULT after edge 15 with count 8.
        launch(1'b1, base);
        repeat (7) step();
        check("b_run_outs", 32'(outs_b), 32'b000100);
        push_exp(1'b1, 1'b1, 8, base + 15, "b_fault");
        repeat (8) step();
        check("b_fault_outs", 32'(outs_b), 32'b000001);
        check("b_fault_cnt", cnt_b, 32'd8);

        // Halt synchronized in the same cycle as count 7 -> DONE wins.
        launch(1'b1, base);
        check("b_relaunch_clr", cnt_b, 32'd0);
        repeat (12) step();
        push_exp(1'b1, 1'b0, 8, base + 15, "b_tie");
        halt_b = 1'b1;
        repeat (3) step();
        halt_b = 1'b0;
        check("b_tie_outs", 32'(outs_b), 32'b000010);
        check("b_tie_cnt", cnt_b, 32'd8);

        repeat (3) step();
        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_launch_seq.md
# core_launch_seq

Clocked launch sequencer upstream of the asynchronous core top, `asmodee`. It drives the core's `rst_i`, `boot_i` and `start_i` inputs in a fixed order: flush, boot-address load, start request. It then supervises the run, watching the core's halt indication and bounding the run with a cycle watchdog. It also reports status and cycle count to the test/host side.

## Interface
Parameters:
- `RST_CYCLES`, default 4: cycles `core_rst_o` stays high in RESET; must be ≥ 2 so the halt synchronizer flushes.
- `BOOT_CYCLES`, default 2: cycles `core_boot_o` stays high before the start pulse; must be ≥ 1.
- `TIMEOUT`, default 1000000: maximum RUN cycles before FAULT; must be ≥ 1 and < 2^32.

Ports:
- `clk_i` in 1: clock. This is the block's only clock.
- `rst_i` in 1: synchronous, active-high reset.
- `run_req_i` in 1: launch request, level-sampled; accepted in IDLE, DONE and FAULT.
- `abort_i` in 1: cancels any launch or run in progress.
- `halt_i` in 1: core end-of-program flag. It is asynchronous to `clk_i` and is synchronized internally.
- `core_rst_o` out 1: drives the core's `rst_i`.
- `core_boot_o` out 1: drives the core's `boot_i`.
- `core_start_o` out 1: drives the core's `start_i`.
- `busy_o` out 1: high in RESET, BOOT, START and RUN.
- `done_o` out 1: high in DONE.
- `timeout_o` out 1: high in FAULT.
- `cycle_count_o` out 32: number of RUN cycles in the current or last run.

## Operation
- States: IDLE, RESET, BOOT, START, RUN, DONE, FAULT. All outputs are Moore-decoded from the state register.
- IDLE: `core_rst_o`=1, all other outputs 0. The core is held flushed while idle.
  - `run_req_i`=1 → RESET.
- RESET: `core_rst_o`=1 and `busy_o`=1. A phase counter loads on entry and runs for RST_CYCLES cycles, then → BOOT.
  - On entry, `cycle_count_o` clears to 0.
- BOOT: `core_boot_o`=1, `core_rst_o`=0. Lasts BOOT_CYCLES cycles, then → START.
- START: `core_boot_o`=1 and `core_start_o`=1 for exactly one cycle, then → RUN.
- RUN: all core outputs are 0 and `cycle_count_o` increments by 1 every cycle.
  - Synchronized halt = 1 → DONE.
  - Otherwise, when `cycle_count_o` == TIMEOUT−1 → FAULT. The count reaches TIMEOUT on that transition.
  - Halt and the timeout condition in the same cycle: halt wins, → DONE.
- DONE / FAULT: `core_rst_o`=0, so core and memory state stay inspectable. `cycle_count_o` is frozen.
  - `run_req_i`=1 → RESET (relaunch). There is no route back to IDLE except abort or reset.
- `abort_i`=1 in RESET, BOOT, START or RUN → IDLE next cycle, which re-asserts `core_rst_o`. `cycle_count_o` keeps its value.
  - `abort_i` has priority over every other transition.
  - In IDLE, DONE and FAULT, `abort_i` → IDLE.
- Halt path: two-flop synchronizer, level-sensitive. Any stale halt from a previous run is cleared because the core reset lasts at least RST_CYCLES ≥ 2 cycles.
- Counter arithmetic: `cycle_count_o` is unsigned 32-bit and never exceeds TIMEOUT, so it cannot wrap.

## Timing
- Reset values: state IDLE, `core_rst_o`=1, every other output 0, `cycle_count_o`=0, synchronizer flops 0.
- Latency with defaults: `run_req_i` sampled high at edge 0.
  - `core_rst_o` stays high through edge 4.
  - `core_boot_o` is high from edge 4 to edge 7.
  - `core_start_o` is high from edge 6 to edge 7.
  - RUN starts at edge 7.
- General start edge: RST_CYCLES + BOOT_CYCLES.
- Halt latency: `halt_i` first sampled high at edge n → `done_o` high after edge n+2. `cycle_count_o` counts every RUN cycle up to that transition.
- `core_boot_o` and `core_start_o` are never high while `core_rst_o` is high. Mutual exclusion is a required assertion.

## Structure
- Shared package `pkg`: typedef `launch_state_e` (the 7 states) and the constant `CYCLE_CNT_W` = 32.
- Sub-module `sync_2ff`: 1-bit two-flop synchronizer with synchronous reset to 0, used on `halt_i`.
- Phase counter: `$clog2(max(RST_CYCLES, BOOT_CYCLES)+1)` bits, shared by RESET and BOOT.

## Test plan
- After reset, hold `run_req_i`=0 for 10 cycles → `core_rst_o`=1, all other outputs 0.
- `run_req_i` pulse at edge 0 with defaults, `halt_i` raised 20 cycles into RUN → `core_start_o` seen for one cycle after edge 6. `done_o` rises 2 edges after halt is sampled; `cycle_count_o` = 22.
- TIMEOUT=8 with `halt_i` never raised → FAULT after 8 RUN cycles; `timeout_o`=1, `cycle_count_o`=8.
- TIMEOUT=8 with `halt_i` sampled at the edge where the synchronized halt coincides with count 7 → DONE, not FAULT.
- `abort_i` during BOOT and again during RUN → IDLE the next cycle, `core_rst_o`=1, `busy_o`=0.
- `run_req_i` in DONE → RESET, `cycle_count_o` clears to 0, and the full sequence repeats. `rst_i` asserted mid-RUN → all outputs at their reset values on the next edge.
